// File: rtl/mips_divider_if.sv
// rtl/mips_divider_if.sv - start/result handshake bundle for the MIPS DIV/DIVU unit
interface mips_divider_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mips_divider.sv
// rtl/mips_divider.sv - 32-cycle restoring divider producing LO (quotient) and HI (remainder)
module mips_divider (
  input  logic          clk,
  input  logic          reset,
  mips_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_next;
  logic        load, step, finish;
  logic [4:0]  count;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_mag;
  logic [31:0] dividend_raw;
  logic        neg_quo, neg_rem, dz_q;
  logic        done_q, div_by_zero_q;
  logic [31:0] quotient_q, remainder_q;

  logic [31:0] dividend_mag, divisor_mag;
  logic [33:0] shifted, trial;

  assign dividend_mag = (bus.is_signed && bus.dividend[31]) ? (~bus.dividend + 32'd1) : bus.dividend;
  assign divisor_mag  = (bus.is_signed && bus.divisor[31])  ? (~bus.divisor + 32'd1)  : bus.divisor;

  // Sign bit of the 34-bit trial result is the borrow that selects restore.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {2'b00, dvs_mag};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = (bus.divisor == 32'd0) ? FIX : RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == 5'd31) state_next = FIX;
      end
      FIX: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= 5'd0;
      rem_q         <= 33'd0;
      quo_q         <= 32'd0;
      dvs_mag       <= 32'd0;
      dividend_raw  <= 32'd0;
      neg_quo       <= 1'b0;
      neg_rem       <= 1'b0;
      dz_q          <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      quotient_q    <= 32'd0;
      remainder_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        quo_q         <= dividend_mag;
        dvs_mag       <= divisor_mag;
        dividend_raw  <= bus.dividend;
        neg_quo       <= bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]);
        neg_rem       <= bus.is_signed & bus.dividend[31];
        dz_q          <= (bus.divisor == 32'd0);
        rem_q         <= 33'd0;
        count         <= 5'd0;
        div_by_zero_q <= 1'b0;
      end
      if (step) begin
        count <= count + 5'd1;
        if (!trial[33]) begin
          rem_q <= trial[32:0];
          quo_q <= {quo_q[30:0], 1'b1};
        end else begin
          rem_q <= shifted[32:0];
          quo_q <= {quo_q[30:0], 1'b0};
        end
      end
      if (finish) begin
        done_q        <= 1'b1;
        div_by_zero_q <= dz_q;
        if (dz_q) begin
          quotient_q  <= 32'hFFFF_FFFF;
          remainder_q <= dividend_raw;
        end else begin
          quotient_q  <= neg_quo ? (~quo_q + 32'd1) : quo_q;
          remainder_q <= neg_rem ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
        end
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_mips_divider.sv
// tb/tb_mips_divider.sv - randomized scoreboard bench for mips_divider
module tb_mips_divider;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_divider_if bus();
  mips_divider dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          busy_cnt = 0;
  logic [31:0] last_q = 32'd0;
  logic [31:0] last_r = 32'd0;
  logic        prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint na, nb, qq, rr;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else begin
      if (sgn) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'd0, a});
        nb = longint'({32'd0, b});
      end
      qq = na / nb;
      rr = na % nb;
      e.q = qq[31:0]; e.r = rr[31:0]; e.dz = 1'b0; e.lat = 33;
    end
    return e;
  endfunction

  // Monitor: compares every done against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt  = 0;
      last_q    = 32'd0;
      last_r    = 32'd0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy) begin
        busy_cnt++;
        chk("hold_quotient", bus.quotient, last_q);
        chk("hold_remainder", bus.remainder, last_r);
      end
      if (bus.done) begin
        chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", bus.quotient, e.q);
          chk("remainder", bus.remainder, e.r);
          chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
          chk("latency", busy_cnt, e.lat);
        end
        last_q   = bus.quotient;
        last_r   = bus.remainder;
        busy_cnt = 0;
      end
      prev_done = bus.done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t e;
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.is_signed = ~sgn;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    if (track) begin
      e = model(sgn, a, b);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    issue(sgn, a, b, 1'b1);
  endtask

  initial begin
    logic [31:0] a, b;
    bit          sgn;
    int          n;

    reset = 1'b1; bus.start = 1'b0; bus.is_signed = 1'b0;
    bus.dividend = 32'd0; bus.divisor = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_quotient", bus.quotient, 32'd0);
    chk("reset_remainder", bus.remainder, 32'd0);
    chk("reset_dz", {31'd0, bus.div_by_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd100, 32'd7);
    run_op(1'b1, -32'sd7, 32'd2);
    run_op(1'b1, 32'd7, -32'sd2);
    run_op(1'b1, -32'sd7, -32'sd2);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'd5, 32'd9);
    run_op(1'b1, 32'd1234, 32'd0);
    run_op(1'b0, 32'd10, 32'd3);

    // start pulses during RUN must not disturb the operation in flight
    run_op(1'b0, 32'd1000, 32'd33);
    for (int i = 0; i < 3; i++) begin
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.is_signed = 1'b1;
      bus.dividend = $urandom; bus.divisor = 32'd0;
      @(negedge clk);
      bus.start = 1'b0;
    end

    // start in the done cycle
    wait_idle();
    chk("done_cycle_for_restart", {31'd0, bus.done}, 32'd1);
    issue(1'b0, 32'd77, 32'd5, 1'b1);

    // reset mid-operation
    wait_idle();
    issue(1'b0, 32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset_done", {31'd0, bus.done}, 32'd0);
    chk("midreset_quotient", bus.quotient, 32'd0);
    chk("midreset_remainder", bus.remainder, 32'd0);
    chk("midreset_dz", {31'd0, bus.div_by_zero}, 32'd0);
    repeat (40) @(negedge clk);
    run_op(1'b0, 32'd81, 32'd9);

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom % 2);
      a   = $urandom;
      case ($urandom % 4)
        0: b = $urandom;
        1: b = 32'($urandom % 16) + 32'd1;
        2: b = (($urandom % 4) == 0) ? 32'd0 : 32'($urandom % 1000);
        default: b = ~(32'($urandom % 16));
      endcase
      if (i % 5 == 0) a = 32'h8000_0000;
      run_op(sgn, a, b);
    end

    wait_idle();
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
